// File: rtl/instr_sequencer.sv
// Four-phase fetch/decode/issue sequencer for the 32x8 register/stack memory.
// Each instruction ends in one write-enabled issue cycle; pending interrupts ride along on eint.
module instr_sequencer #(
    parameter int unsigned IW            = 17,
    parameter bit          ISR_ADDR_MASK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    pc_in,
    output logic [7:0]    rom_addr,
    input  logic [IW-1:0] rom_data,
    input  logic [7:0]    mem_rdata,
    input  logic          irq,
    output logic [4:0]    mem_addr,
    output logic [7:0]    mem_wdata,
    output logic [7:0]    literal,
    output logic [1:0]    csrc,
    output logic          wr_en,
    output logic [1:0]    cpc,
    output logic          call,
    output logic          ret,
    output logic          push,
    output logic          pop,
    output logic          eint,
    output logic          halted,
    output logic          illegal
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StSettle, StHalt} state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpMovl = 4'h1;
    localparam logic [3:0] OpMova = 4'h2;
    localparam logic [3:0] OpMovc = 4'h3;
    localparam logic [3:0] OpSkpc = 4'h4;
    localparam logic [3:0] OpCall = 4'h5;
    localparam logic [3:0] OpRet  = 4'h6;
    localparam logic [3:0] OpPush = 4'h7;
    localparam logic [3:0] OpPop  = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpHalt = 4'hA;

    state_e      state_q;
    logic [3:0]  op_q;
    logic [4:0]  iaddr_q;
    logic [7:0]  rom_addr_q, mem_wdata_q, literal_q;
    logic [4:0]  mem_addr_q;
    logic [1:0]  csrc_q, cpc_q;
    logic        wr_en_q, call_q, ret_q, push_q, pop_q, eint_q, halted_q, illegal_q;
    logic        irq_q, irq_pending_q, irq_pending_d, in_isr_q;
    logic        irq_rise, eligible, merge;

    always_comb begin
        irq_rise = irq & ~irq_q;
        eligible = ((op_q <= OpMovc) || (op_q == OpPush) || (op_q == OpPop)) &&
                   (iaddr_q != 5'h0C) && (iaddr_q != 5'h1E) &&
                   (!in_isr_q || !ISR_ADDR_MASK);
        // An edge seen during DECODE can still merge into this instruction's EXEC.
        merge = (state_q == StDecode) && (op_q != OpHalt) && eligible &&
                (irq_pending_q | irq_rise);
        // When an older request is consumed, a fresh edge in the same cycle stays pending.
        irq_pending_d = merge ? (irq_pending_q & irq_rise) : (irq_pending_q | irq_rise);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            op_q          <= 4'h0;
            iaddr_q       <= 5'h0;
            rom_addr_q    <= 8'h0;
            mem_addr_q    <= 5'h0;
            mem_wdata_q   <= 8'h0;
            literal_q     <= 8'h0;
            csrc_q        <= 2'b00;
            cpc_q         <= 2'd0;
            wr_en_q       <= 1'b0;
            call_q        <= 1'b0;
            ret_q         <= 1'b0;
            push_q        <= 1'b0;
            pop_q         <= 1'b0;
            eint_q        <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
            irq_q         <= 1'b0;
            irq_pending_q <= 1'b0;
            in_isr_q      <= 1'b0;
        end else begin
            irq_q         <= irq;
            irq_pending_q <= irq_pending_d;
            unique case (state_q)
                StFetch: begin
                    op_q       <= rom_data[IW-1 -: 4];
                    iaddr_q    <= rom_data[IW-5 -: 5];
                    // Address goes out now so mem_rdata is valid for the whole DECODE cycle.
                    mem_addr_q <= (rom_data[IW-1 -: 4] == OpJmp) ? 5'h0C : rom_data[IW-5 -: 5];
                    literal_q  <= rom_data[7:0];
                    state_q    <= StDecode;
                end
                StDecode: begin
                    mem_wdata_q <= mem_rdata;
                    if (op_q == OpHalt) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        wr_en_q <= 1'b1;
                        eint_q  <= merge;
                        csrc_q  <= 2'b00;
                        cpc_q   <= 2'd1;
                        state_q <= StExec;
                        if (merge) in_isr_q <= 1'b1;
                        case (op_q)
                            OpNop:  ;
                            OpMovl: csrc_q <= 2'b01;
                            OpMova: csrc_q <= 2'b10;
                            OpMovc: csrc_q <= 2'b11;
                            OpSkpc: cpc_q  <= 2'd2;
                            OpCall: begin
                                cpc_q  <= 2'd0;
                                call_q <= 1'b1;
                            end
                            OpRet: begin
                                cpc_q    <= 2'd0;
                                ret_q    <= 1'b1;
                                in_isr_q <= 1'b0;
                            end
                            OpPush: push_q <= 1'b1;
                            OpPop:  pop_q  <= 1'b1;
                            OpJmp: begin
                                csrc_q <= 2'b01;
                                cpc_q  <= 2'd0;
                            end
                            default: illegal_q <= 1'b1;
                        endcase
                    end
                end
                StExec: begin
                    wr_en_q <= 1'b0;
                    csrc_q  <= 2'b00;
                    cpc_q   <= 2'd0;
                    call_q  <= 1'b0;
                    ret_q   <= 1'b0;
                    push_q  <= 1'b0;
                    pop_q   <= 1'b0;
                    eint_q  <= 1'b0;
                    state_q <= StSettle;
                end
                StSettle: begin
                    rom_addr_q <= pc_in;
                    state_q    <= StFetch;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign literal   = literal_q;
    assign csrc      = csrc_q;
    assign wr_en     = wr_en_q;
    assign cpc       = cpc_q;
    assign call      = call_q;
    assign ret       = ret_q;
    assign push      = push_q;
    assign pop       = pop_q;
    assign eint      = eint_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural ROM and register/PC memory model, issue scoreboard
// popped on every wr_en cycle, plus directed PC/LNK/flag checks.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst, irq;
    logic [7:0]  pc_in, rom_addr, mem_rdata, mem_wdata, literal;
    logic [16:0] rom_data;
    logic [4:0]  mem_addr;
    logic [1:0]  csrc, cpc;
    logic        wr_en, call, ret, push, pop, eint, halted, illegal;

    always #5 clk = ~clk;

    instr_sequencer #(.IW(17), .ISR_ADDR_MASK(1'b1)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .rom_addr(rom_addr), .rom_data(rom_data),
        .mem_rdata(mem_rdata), .irq(irq), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .literal(literal), .csrc(csrc), .wr_en(wr_en), .cpc(cpc), .call(call), .ret(ret),
        .push(push), .pop(pop), .eint(eint), .halted(halted), .illegal(illegal)
    );

    // Program ROM and memory model
    logic [16:0] rom [256];
    logic [7:0]  m_regs [32];
    logic [7:0]  m_pc, m_lnk;
    logic        ceenz;

    assign rom_data  = rom[rom_addr];
    assign pc_in     = m_pc;
    assign mem_rdata = m_regs[mem_addr];

    always @(posedge clk) begin
        if (rst) begin
            m_pc  <= 8'h00;
            m_lnk <= 8'h00;
            for (int i = 0; i < 32; i++) m_regs[i] <= 8'(8'hA0 + i);
        end else if (wr_en) begin
            case (csrc)
                2'b01:   m_regs[mem_addr] <= literal;
                2'b00:   m_regs[mem_addr] <= mem_wdata;
                default: ;
            endcase
            if (eint) begin
                m_lnk <= m_pc;
                m_pc  <= 8'(8'd249 + 8'(cpc));
            end else if (call) begin
                m_lnk <= m_pc;
                m_pc  <= literal;
            end else if (ret) begin
                m_pc <= m_lnk + 8'd1;
            end else begin
                case (cpc)
                    2'd1:    m_pc <= m_pc + 8'd1;
                    2'd2:    m_pc <= m_pc + (ceenz ? 8'd1 : 8'd2);
                    default: m_pc <= literal;
                endcase
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard entry: {mem_addr, literal, csrc, cpc, call, ret, push, pop, eint}
    logic [21:0] sb_q [$];

    function automatic logic [21:0] mk(input logic [4:0] a, input logic [7:0] l,
                                       input logic [1:0] cs, input logic [1:0] cp,
                                       input logic [3:0] strb, input logic ei);
        return {a, l, cs, cp, strb, ei};
    endfunction

    function automatic logic [16:0] ins(input logic [3:0] op, input logic [4:0] a,
                                        input logic [7:0] l);
        return {op, a, l};
    endfunction

    task automatic push_isr();
        sb_q.push_back(mk(5'd2, 8'h11, 2'b01, 2'd1, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'd0, 8'h00, 2'b00, 2'd1, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'd0, 8'h00, 2'b00, 2'd0, 4'b0100, 1'b0));
    endtask

    logic        prev_wr = 1'b0;
    logic [21:0] sb_exp;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check("wr_pulse", 32'(prev_wr), 32'd0);
            if (sb_q.size() == 0) begin
                check("sb_extra", 32'(wr_en), 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("issue", 32'({mem_addr, literal, csrc, cpc, call, ret, push, pop, eint}),
                      32'(sb_exp));
            end
            check("wdata", 32'(mem_wdata), 32'(m_regs[mem_addr]));
        end
        prev_wr <= wr_en;
    end

    task automatic wait_fetch(input logic [7:0] a, input string tag);
        int n = 0;
        while (rom_addr !== a && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rom_addr), 32'(a));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, 32'({rom_addr, mem_addr, mem_wdata, literal}), 32'd0);
        check({tag, "_ctl"}, 32'({csrc, wr_en, cpc, call, ret, push, pop, eint, halted, illegal}),
              32'd0);
    endtask

    initial begin
        int wr_cnt;
        rst   = 1'b1;
        irq   = 1'b0;
        ceenz = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 17'h0;
        rom[8'h00] = ins(4'h1, 5'd3, 8'h5A);
        rom[8'h01] = ins(4'h9, 5'd0, 8'h10);
        rom[8'h10] = ins(4'h5, 5'd0, 8'h40);
        rom[8'h40] = ins(4'h6, 5'd0, 8'h00);
        rom[8'h11] = ins(4'h9, 5'd0, 8'h20);
        rom[8'h20] = ins(4'h4, 5'd0, 8'h00);
        rom[8'h21] = ins(4'h9, 5'd0, 8'h20);
        rom[8'h22] = ins(4'h9, 5'd0, 8'h30);
        rom[8'h30] = ins(4'h1, 5'd1, 8'h77);
        rom[8'hFA] = ins(4'h1, 5'd2, 8'h11);
        rom[8'hFB] = ins(4'h0, 5'd0, 8'h00);
        rom[8'hFC] = ins(4'h6, 5'd0, 8'h00);
        rom[8'h31] = ins(4'h0, 5'd0, 8'h00);
        rom[8'h32] = ins(4'h5, 5'd0, 8'h50);
        rom[8'h50] = ins(4'h0, 5'd0, 8'h00);
        rom[8'h51] = ins(4'hA, 5'd0, 8'h00);

        sb_q.push_back(mk(5'd3,  8'h5A, 2'b01, 2'd1, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'h0C, 8'h10, 2'b01, 2'd0, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'd0,  8'h40, 2'b00, 2'd0, 4'b1000, 1'b0));
        sb_q.push_back(mk(5'd0,  8'h00, 2'b00, 2'd0, 4'b0100, 1'b0));
        sb_q.push_back(mk(5'h0C, 8'h20, 2'b01, 2'd0, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'd0,  8'h00, 2'b00, 2'd2, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'h0C, 8'h20, 2'b01, 2'd0, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'd0,  8'h00, 2'b00, 2'd2, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'h0C, 8'h30, 2'b01, 2'd0, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'd1,  8'h77, 2'b01, 2'd1, 4'b0000, 1'b1));
        push_isr();
        sb_q.push_back(mk(5'd0,  8'h00, 2'b00, 2'd1, 4'b0000, 1'b1));
        push_isr();
        sb_q.push_back(mk(5'd0,  8'h50, 2'b00, 2'd0, 4'b1000, 1'b0));
        sb_q.push_back(mk(5'd0,  8'h00, 2'b00, 2'd1, 4'b0000, 1'b1));
        push_isr();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        wait_fetch(8'h01, "fetch_01");
        check("movl_r3", 32'(m_regs[3]), 32'h5A);
        wait_fetch(8'h10, "jmp_10");
        wait_fetch(8'h40, "call_40");
        check("lnk_call", 32'(m_lnk), 32'h10);
        wait_fetch(8'h11, "ret_11");
        wait_fetch(8'h20, "jmp_20");
        wait_fetch(8'h21, "skpc_ceenz1");
        ceenz = 1'b0;
        wait_fetch(8'h22, "skpc_ceenz0");
        wait_fetch(8'h30, "jmp_30");
        // Pulse irq so its edge lands in the DECODE cycle of MOVL R1.
        @(posedge clk);
        #1 irq = 1'b1;
        @(posedge clk);
        #1 irq = 1'b0;
        @(negedge clk);
        wait_fetch(8'hFA, "isr_entry1");
        check("lnk_isr1", 32'(m_lnk), 32'h30);
        check("movl_r1", 32'(m_regs[1]), 32'h77);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        wait_fetch(8'h31, "isr_ret1");
        wait_fetch(8'hFA, "isr_entry2");
        check("lnk_isr2", 32'(m_lnk), 32'h31);
        wait_fetch(8'h32, "isr_ret2");
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        wait_fetch(8'h50, "call_50");
        check("lnk_call2", 32'(m_lnk), 32'h32);
        wait_fetch(8'hFA, "isr_entry3");
        check("lnk_isr3", 32'(m_lnk), 32'h50);
        wait_fetch(8'h51, "isr_ret3");
        begin
            int n = 0;
            while (halted !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        check("halted", 32'(halted), 32'd1);
        wr_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en !== 1'b0) wr_cnt++;
        end
        check("halt_quiet", 32'(wr_cnt), 32'd0);
        check("sb_drain1", 32'(sb_q.size()), 32'd0);

        // Illegal opcode after reset, then reset in the middle of an EXEC
        rst = 1'b1;
        rom[8'h00] = ins(4'hC, 5'd4, 8'h00);
        rom[8'h01] = ins(4'h1, 5'd5, 8'h33);
        sb_q.push_back(mk(5'd4, 8'h00, 2'b00, 2'd1, 4'b0000, 1'b0));
        sb_q.push_back(mk(5'd5, 8'h33, 2'b01, 2'd1, 4'b0000, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_fetch(8'h01, "fetch_after_ill");
        check("illegal", 32'(illegal), 32'd1);
        check("halted_clr", 32'(halted), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("exec_wr", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("rst_exec");
        check("sb_drain2", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/issue sequencer directly upstream of the 32x8 register/stack memory.
- Reads the memory's PC output, fetches a 17-bit instruction from a combinational program ROM, and decodes it.
- Drives one write-enabled issue cycle carrying the memory's control strobes: addr, data_in, literal, csrc, CPC, call, ret, push, pop, eint.
- Also merges external interrupt requests into instruction boundaries.

Parameters:
- IW, 17, instruction width: op[16:13], addr[12:8], lit[7:0].
- ISR_ADDR_MASK, 1, when 1 a second interrupt is blocked until RET.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- pc_in  in  8  PC output of the memory.
- rom_addr  out  8  program ROM address.
- rom_data  in  17  program ROM word, combinational.
- mem_rdata  in  8  memory data_out.
- irq  in  1  external interrupt request, level, synchronous.
- mem_addr  out  5  to memory addr.
- mem_wdata  out  8  to memory data_in.
- literal  out  8  to memory literal.
- csrc  out  2  to memory csrc.
- wr_en  out  1  to memory wr_en.
- cpc  out  2  to memory CPC.
- call, ret, push, pop, eint  out  1 each  to the memory's same-named strobes.
- halted  out  1  HALT executed.
- illegal  out  1  sticky, undefined opcode seen.

Behaviour:
- Reset: sync active-high; state=FETCH; all outputs 0; internal irq_pending=0, in_isr=0.
- Reset mid-EXEC drops wr_en the same edge, and no strobe survives.
- FSM, 4 cycles per instruction: FETCH -> DECODE -> EXEC -> SETTLE -> FETCH. All outputs are registered.
- FETCH:
  - rom_addr<=pc_in.
  - At the edge, instr<=rom_data; rom_addr is held from the previous cycle.
  - ROM latency is zero.
- DECODE:
  - mem_addr<=instr.addr, literal<=instr.lit.
  - At the end, rdata_q<=mem_rdata.
- EXEC:
  - wr_en=1 for exactly one cycle.
  - mem_wdata=rdata_q, so csrc=00 is a harmless rewrite.
  - Per-opcode controls apply (list below).
- SETTLE: wr_en=0 and all strobes 0; lets the memory PC update before the next FETCH.
- Opcodes, with csrc / cpc / strobe:
  - 0 NOP: 00 / 1.
  - 1 MOVL: 01 / 1.
  - 2 MOVA: 10 / 1.
  - 3 MOVC: 11 / 1.
  - 4 SKPC: 00 / 2; the memory adds 1 if CEENZ else 2.
  - 5 CALL: 00 / 0 / call.
  - 6 RET: 00 / 0 / ret; clears in_isr.
  - 7 PUSH: 00 / 1 / push.
  - 8 POP: 00 / 1 / pop.
  - 9 JMP: forces mem_addr=0x0C, 01 / 0.
  - A HALT: no wr_en; go to HALT state; leave only via rst.
  - B-F: executed as NOP; illegal<=1, sticky until rst.
- Interrupt request capture:
  - A rising edge of irq (1-cycle registered compare) sets irq_pending.
  - A set and a clear in the same cycle: set wins.
- Interrupt merge:
  - Pending merges into the EXEC of the next eligible instruction by adding eint=1.
  - Eligible: op in {0,1,2,3,7,8}, instr.addr not 0x0C/0x1E, and (!in_isr or ISR_ADDR_MASK=0).
  - The memory then saves LNK=current PC and sets PC=249; cpc=1 yields 250. RET resumes at the interrupted PC+1.
  - On merge: irq_pending<=0, in_isr<=1.
- Ineligible instructions issue unchanged; pending persists.
- In HALT, pending is held and not serviced.
- At most one strobe of {call, ret, push, pop} is asserted per EXEC.

Test Plan:
- MOVL to R3, lit 0x5A:
  - Response: wr_en high exactly one cycle in the 3rd cycle after FETCH; csrc=01, cpc=1, mem_addr=3, literal=0x5A.
  - Memory R3=0x5A, PC+1.
- CALL 0x40 at PC 0x10, then RET at 0x40:
  - CALL response: call strobe one cycle, cpc=0; PC=0x40, LNK=0x10.
  - RET response: ret strobe, PC=0x11.
- SKPC with CEENZ=1 vs 0 at PC 0x20:
  - Response: cpc=2; next fetch address 0x21 vs 0x22 respectively.
- irq pulse during DECODE of MOVL R1 at PC 0x30:
  - Response: eint with wr_en in that EXEC; R1 written, LNK=0x30, PC=250.
  - A second irq is ignored until RET; RET gives PC=0x31.
- irq pending while CALL executes:
  - Response: no eint on CALL; eint merges on the next NOP.
- HALT then opcode 0xC after rst:
  - HALT response: halted=1; no further wr_en for 20 cycles.
  - Opcode 0xC response: NOP behaviour, illegal=1.
  - rst asserted during EXEC: wr_en=0 at the next edge, all outputs 0.
